// File: rtl/wb_sched_pkg.sv
// wb_sched_pkg: shared state encoding for the cellram port scheduler; values double as mst_sel codes.
package wb_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_M0 = 2'b01, GNT_M1 = 2'b10} state_t;
endpackage

// File: rtl/wb_mem_scheduler_if.sv
// wb_mem_scheduler_if: one Wishbone link; master drives the request, slave returns data/ack/err.
interface wb_mem_scheduler_if;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        cyc, stb, we, ack, err;
  modport master (output adr, dat_w, sel, cyc, stb, we, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, cyc, stb, we, output dat_r, ack, err);
endinterface

// File: rtl/wb_sched_watchdog.sv
// wb_sched_watchdog: counts strobed cycles without ack and flags the cycle a transfer must be aborted.
module wb_sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 9
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic expire
);
  logic [CNT_W-1:0] to_cnt;
  assign expire = stb && !ack && to_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_50mhz or posedge rst)
    if (rst) to_cnt <= '0;
    else to_cnt <= (!stb || ack || expire) ? '0 : to_cnt + 1'b1;
endmodule

// File: rtl/wb_mem_scheduler.sv
// wb_mem_scheduler: shares the cellram port between vcache (m0, priority) and CPU (m1, starvation guard).
module wb_mem_scheduler
  import wb_sched_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 9
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  wb_mem_scheduler_if.slave  m0,
  wb_mem_scheduler_if.slave  m1,
  wb_mem_scheduler_if.master s,
  output logic [1:0]         mst_sel
);
  state_t state, nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic g0, g1, expire, err0, err1, m1_urgent;
  assign g0 = state == GNT_M0;
  assign g1 = state == GNT_M1;
  assign m1_urgent = m1.cyc && wait_cnt >= CNT_W'(MAX_WAIT);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = m1_urgent ? GNT_M1 : m0.cyc ? GNT_M0 : m1.cyc ? GNT_M1 : IDLE;
      GNT_M0:  nxt = (expire || !m0.cyc) ? IDLE : GNT_M0;
      GNT_M1:  nxt = (expire || !m1.cyc) ? IDLE : GNT_M1;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_50mhz or posedge rst)
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      err0     <= 1'b0;
      err1     <= 1'b0;
    end else begin
      state    <= nxt;
      wait_cnt <= (!m1.cyc || (nxt == GNT_M1 && !g1)) ? '0 :
                  (!g1 && wait_cnt < CNT_W'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
      err0     <= expire && g0;
      err1     <= expire && g1;
    end
  assign mst_sel = state;
  assign s.adr   = g0 ? m0.adr : g1 ? m1.adr : '0;
  assign s.dat_w = g0 ? m0.dat_w : g1 ? m1.dat_w : '0;
  assign s.sel   = g0 ? m0.sel : g1 ? m1.sel : '0;
  assign s.cyc   = (g0 && m0.cyc) || (g1 && m1.cyc);
  assign s.stb   = (g0 && m0.stb) || (g1 && m1.stb);
  assign s.we    = (g0 && m0.we) || (g1 && m1.we);
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = g0 && s.ack;
  assign m1.ack   = g1 && s.ack;
  assign m0.err   = err0;
  assign m1.err   = err1;
  wb_sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wd (
    .clk_50mhz(clk_50mhz),
    .rst(rst),
    .stb(s.stb),
    .ack(s.ack),
    .expire(expire)
  );
endmodule

// File: tb/tb_wb_mem_scheduler.sv
// tb_wb_mem_scheduler: directed corner cases plus random traffic against a cycle-level scheduler model.
module tb_wb_mem_scheduler;
  localparam int MW = 64;
  localparam int TO = 256;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mst_sel;
  int total = 0, bad = 0, n = 0;
  int own = 0, waited = 0, stall = 0;
  bit x0 = 0, x1 = 0;
  logic [31:0] seen_sel, seen_adr, seen_wdat, seen_sel4, seen_dat0;
  logic seen_we, seen_scyc, seen_ack0, seen_ack1, seen_err0, seen_err1;
  wb_mem_scheduler_if m0_if ();
  wb_mem_scheduler_if m1_if ();
  wb_mem_scheduler_if s_if ();
  wb_mem_scheduler #(.MAX_WAIT(MW), .TIMEOUT_CYCLES(TO), .CNT_W(9)) dut (
    .clk_50mhz(clk),
    .rst(rst),
    .m0(m0_if),
    .m1(m1_if),
    .s(s_if),
    .mst_sel(mst_sel)
  );
  always #10 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, n);
    end
  endtask
  task automatic model_reset();
    own = 0; waited = 0; stall = 0; x0 = 0; x1 = 0;
  endtask
  task automatic cycle();
    logic gc, gs, gw, expire;
    logic [31:0] ga, gd, gsel;
    int nown;
    @(negedge clk);
    gc   = own == 1 ? m0_if.cyc : own == 2 ? m1_if.cyc : 1'b0;
    gs   = own == 1 ? m0_if.stb : own == 2 ? m1_if.stb : 1'b0;
    gw   = own == 1 ? m0_if.we : own == 2 ? m1_if.we : 1'b0;
    ga   = own == 1 ? m0_if.adr : own == 2 ? m1_if.adr : 32'h0;
    gd   = own == 1 ? m0_if.dat_w : own == 2 ? m1_if.dat_w : 32'h0;
    gsel = own == 1 ? {28'h0, m0_if.sel} : own == 2 ? {28'h0, m1_if.sel} : 32'h0;
    chk("mst_sel", {30'h0, mst_sel}, own);
    chk("s_cyc", {31'h0, s_if.cyc}, {31'h0, gc});
    chk("s_stb", {31'h0, s_if.stb}, {31'h0, gs});
    chk("s_we", {31'h0, s_if.we}, {31'h0, gw});
    chk("s_adr", s_if.adr, ga);
    chk("s_dat", s_if.dat_w, gd);
    chk("s_sel", {28'h0, s_if.sel}, gsel);
    chk("m0_ack", {31'h0, m0_if.ack}, {31'h0, own == 1 && s_if.ack});
    chk("m1_ack", {31'h0, m1_if.ack}, {31'h0, own == 2 && s_if.ack});
    chk("m0_err", {31'h0, m0_if.err}, {31'h0, x0});
    chk("m1_err", {31'h0, m1_if.err}, {31'h0, x1});
    chk("m0_dat", m0_if.dat_r, s_if.dat_r);
    chk("m1_dat", m1_if.dat_r, s_if.dat_r);
    seen_sel = {30'h0, mst_sel}; seen_adr = s_if.adr; seen_wdat = s_if.dat_w;
    seen_sel4 = {28'h0, s_if.sel}; seen_dat0 = m0_if.dat_r; seen_we = s_if.we;
    seen_scyc = s_if.cyc; seen_ack0 = m0_if.ack; seen_ack1 = m1_if.ack;
    seen_err0 = m0_if.err; seen_err1 = m1_if.err;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      expire = own != 0 && gs && !s_if.ack && stall == TO - 1;
      nown = own == 0 ? ((m1_if.cyc && waited >= MW) ? 2 : m0_if.cyc ? 1 : m1_if.cyc ? 2 : 0)
                      : (expire || !gc) ? 0 : own;
      x0 = expire && own == 1;
      x1 = expire && own == 2;
      stall = (gs && !s_if.ack && !expire) ? stall + 1 : 0;
      waited = (!m1_if.cyc || (nown == 2 && own != 2)) ? 0 :
               own != 2 ? (waited < MW ? waited + 1 : MW) : waited;
      own = nown;
    end
    #1;
    n++;
  endtask
  task automatic drive(input int m, input logic c, input logic st, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs);
    if (m == 0) begin
      m0_if.cyc = c; m0_if.stb = st; m0_if.we = w; m0_if.adr = a; m0_if.dat_w = d; m0_if.sel = bs;
    end else begin
      m1_if.cyc = c; m1_if.stb = st; m1_if.we = w; m1_if.adr = a; m1_if.dat_w = d; m1_if.sel = bs;
    end
  endtask
  initial begin
    int t0, t1;
    logic c0, c1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    s_if.ack = 0; s_if.dat_r = 0; s_if.err = 0;
    repeat (2) cycle();
    rst = 0;
    cycle();
    // reset mid-read on m0 with the slave acking
    drive(0, 1, 1, 0, 32'h100, 0, 4'hf);
    s_if.ack = 1; s_if.dat_r = 32'h0badf00d;
    repeat (3) cycle();
    chk("pre_rst_sel", seen_sel, 1);
    #4 rst = 1;
    #1;
    chk("rst_sel", {30'h0, mst_sel}, 0);
    chk("rst_scyc", {31'h0, s_if.cyc}, 0);
    chk("rst_ack0", {31'h0, m0_if.ack}, 0);
    chk("rst_err", {30'h0, m0_if.err, m1_if.err}, 0);
    model_reset();
    cycle();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    s_if.ack = 0;
    cycle();
    // simultaneous requests, then m1 starves behind m0
    drive(0, 1, 1, 0, 32'h200, 0, 4'hf);
    drive(1, 1, 1, 0, 32'h300, 0, 4'h3);
    s_if.ack = 1;
    cycle();
    cycle();
    chk("simul_sel", seen_sel, 1);
    chk("simul_ack1", {31'h0, seen_ack1}, 0);
    repeat (98) cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(0, 1, 1, 0, 32'h204, 0, 4'hf);
    cycle();
    chk("turn_idle", seen_sel, 0);
    cycle();
    chk("starve_sel", seen_sel, 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    // m1 timeout with a silent slave
    s_if.ack = 0;
    drive(1, 1, 1, 0, 32'h400, 0, 4'hf);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (seen_sel == 2 && t0 < 0) t0 = n;
      if (seen_err1) begin t1 = n; break; end
    end
    chk("to_latency", t1 - t0, TO);
    chk("to_scyc", {31'h0, seen_scyc}, 0);
    chk("to_sel", seen_sel, 0);
    cycle();
    chk("to_pulse", {31'h0, seen_err1}, 0);
    chk("to_regrant", seen_sel, 2);
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    // ack arrives on the expiry cycle
    drive(0, 1, 1, 0, 32'h500, 0, 4'hf);
    t0 = 0;
    for (int i = 0; i < 10 && t0 == 0; i++) begin
      cycle();
      if (seen_sel == 1) t0 = 1;
    end
    chk("exp_grant", t0, 1);
    repeat (TO - 2) cycle();
    s_if.ack = 1;
    cycle();
    chk("exp_ack", {31'h0, seen_ack0}, 1);
    s_if.ack = 0;
    cycle();
    chk("exp_noerr", {31'h0, seen_err0}, 0);
    chk("exp_keep", seen_sel, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    // m1 write passthrough
    drive(1, 1, 1, 1, 32'h00f80010, 32'hdeadbeef, 4'hf);
    s_if.ack = 1; s_if.dat_r = 32'h12345678;
    repeat (2) cycle();
    chk("wr_adr", seen_adr, 32'h00f80010);
    chk("wr_dat", seen_wdat, 32'hdeadbeef);
    chk("wr_sel", seen_sel4, 32'hf);
    chk("wr_we", {31'h0, seen_we}, 1);
    chk("wr_m0dat", seen_dat0, 32'h12345678);
    chk("wr_m0ack", {31'h0, seen_ack0}, 0);
    chk("wr_m1ack", {31'h0, seen_ack1}, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    s_if.ack = 0;
    cycle();
    // random traffic
    c0 = 0; c1 = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) c0 = ~c0;
      if ($urandom_range(5) == 0) c1 = ~c1;
      drive(0, c0, c0 && $urandom_range(3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
      drive(1, c1, c1 && $urandom_range(3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
      s_if.ack = (i % 1000) > 700 ? 1'b0 : 1'($urandom);
      s_if.dat_r = $urandom;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
